// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the multi-cycle ALU control block:
//   - alu_code_e : 4-bit ALU control codes driven on ALUCtrl_o
//   - alu_op_e   : main-decoder ALU op classes presented on ALUOp_i
//   - FUNCT_*    : R-type funct field constants
//   - md_op_e    : mult/div operation encoding on md_op_o
//   - state_e    : control FSM states
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SLL     = 4'b0011,
    ALU_SRL     = 4'b0100,
    ALU_SUB     = 4'b0110,
    ALU_SLT     = 4'b0111,
    ALU_PASS_HI = 4'b1000,
    ALU_PASS_LO = 4'b1001,
    ALU_NOR     = 4'b1100,
    ALU_NOP     = 4'b1111
  } alu_code_e;

  typedef enum logic [3:0] {
    OPC_RTYPE = 4'b0000,
    OPC_ADD   = 4'b0001,
    OPC_SUB   = 4'b0010,
    OPC_SLT   = 4'b0011,
    OPC_OR    = 4'b0100,
    OPC_AND   = 4'b0101
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD     = 6'b100000;
  localparam logic [5:0] FUNCT_SUB     = 6'b100010;
  localparam logic [5:0] FUNCT_AND     = 6'b100100;
  localparam logic [5:0] FUNCT_OR      = 6'b100101;
  localparam logic [5:0] FUNCT_NOR     = 6'b100111;
  localparam logic [5:0] FUNCT_SLT     = 6'b101010;
  localparam logic [5:0] FUNCT_SLL     = 6'b000000;
  localparam logic [5:0] FUNCT_SRL     = 6'b000010;
  localparam logic [5:0] FUNCT_MFHI    = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO    = 6'b010010;
  // mult/multu/div/divu occupy 011000..011011; the low two bits select the op.
  localparam logic [3:0] FUNCT_MD_PFX  = 4'b0110;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MD_BUSY = 2'b01,
    ST_MD_DONE = 2'b10
  } state_e;

  // Wide enough for the largest legal MD_CYCLES (255).
  localparam int CNT_W = 8;

endpackage

// File: rtl/alu_dec.sv
// -----------------------------------------------------------------------------
// alu_dec
// Purely combinational ALU control decoder.
// Ports:
//   alu_op_i  [3:0] main-decoder op class
//   funct_i   [5:0] R-type funct field (only used for the R-type class)
//   code_o          ALU control code (NOP for mult/div and illegal requests)
//   is_md_o         request is a mult/div operation
//   md_op_o         mult/div operation (meaningful only when is_md_o)
//   illegal_o       request cannot be decoded
// -----------------------------------------------------------------------------
module alu_dec
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] alu_op_i,
  input  logic [5:0] funct_i,
  output alu_code_e  code_o,
  output logic       is_md_o,
  output md_op_e     md_op_o,
  output logic       illegal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case statements so no
    // path leaves a signal unassigned, which would infer a latch.
    code_o    = ALU_NOP;
    is_md_o   = 1'b0;
    md_op_o   = MD_MULT;
    illegal_o = 1'b0;

    case (alu_op_i)
      OPC_RTYPE: begin
        case (funct_i)
          FUNCT_ADD:  code_o = ALU_ADD;
          FUNCT_SUB:  code_o = ALU_SUB;
          FUNCT_AND:  code_o = ALU_AND;
          FUNCT_OR:   code_o = ALU_OR;
          FUNCT_NOR:  code_o = ALU_NOR;
          FUNCT_SLT:  code_o = ALU_SLT;
          FUNCT_SLL:  code_o = ALU_SLL;
          FUNCT_SRL:  code_o = ALU_SRL;
          FUNCT_MFHI: code_o = ALU_PASS_HI;
          FUNCT_MFLO: code_o = ALU_PASS_LO;
          default: begin
            if (funct_i[5:2] == FUNCT_MD_PFX) begin
              // The ALU itself idles while the mult/div unit works.
              is_md_o = 1'b1;
              md_op_o = md_op_e'(funct_i[1:0]);
            end else begin
              illegal_o = 1'b1;
            end
          end
        endcase
      end
      OPC_ADD: code_o    = ALU_ADD;
      OPC_SUB: code_o    = ALU_SUB;
      OPC_SLT: code_o    = ALU_SLT;
      OPC_OR:  code_o    = ALU_OR;
      OPC_AND: code_o    = ALU_AND;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_mc.sv
// -----------------------------------------------------------------------------
// alu_ctrl_mc
// Registered ALU control with a valid/ready handshake on both sides and a
// sequencer for multi-cycle mult/div operations.
// Single-cycle and illegal requests produce a result one cycle after accept.
// Mult/div requests pulse md_start_o, hold busy_o for MD_CYCLES cycles, then
// present a HI/LO write result (hilo_we_o) that is held until consumed.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   valid_i / ready_o      request handshake (ALUOp_i, funct_i)
//   flush_i                abort any in-flight operation
//   valid_o / ready_i      result handshake (ALUCtrl_o, illegal_o, hilo_we_o)
//   md_start_o, md_op_o    one-cycle mult/div start and operation
//   busy_o                 mult/div in progress
// -----------------------------------------------------------------------------
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [5:0]        funct_i,
  input  logic [3:0]        ALUOp_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              illegal_o,
  output logic              md_start_o,
  output logic [1:0]        md_op_o,
  output logic              busy_o,
  output logic              hilo_we_o
);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  alu_code_e dec_code;
  logic      dec_is_md;
  md_op_e    dec_md_op;
  logic      dec_illegal;

  alu_dec u_dec (
    .alu_op_i  (ALUOp_i),
    .funct_i   (funct_i),
    .code_o    (dec_code),
    .is_md_o   (dec_is_md),
    .md_op_o   (dec_md_op),
    .illegal_o (dec_illegal)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             valid_q,    valid_d;
  alu_code_e        alu_ctrl_q, alu_ctrl_d;
  logic             illegal_q,  illegal_d;
  logic             md_start_q, md_start_d;
  md_op_e           md_op_q,    md_op_d;
  logic             busy_q,     busy_d;
  logic             hilo_we_q,  hilo_we_d;

  logic             ready;
  logic             accept;

  // A new request fits only when idle and the output slot is empty or is
  // being drained this very cycle.
  assign ready  = (state_q == ST_IDLE) && (!valid_q || ready_i);
  assign accept = valid_i && ready;

  always_comb begin
    // Hold everything by default; md_start is a single-cycle pulse.
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    alu_ctrl_d = alu_ctrl_q;
    illegal_d  = illegal_q;
    md_start_d = 1'b0;
    md_op_d    = md_op_q;
    busy_d     = busy_q;
    hilo_we_d  = hilo_we_q;

    if (flush_i) begin
      // Any request presented alongside a flush is dropped.
      state_d   = ST_IDLE;
      cnt_d     = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      busy_d    = 1'b0;
      hilo_we_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Result consumed: empty the slot unless refilled below.
          if (valid_q && ready_i) begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
          end
          if (accept) begin
            if (dec_is_md) begin
              state_d    = ST_MD_BUSY;
              cnt_d      = CNT_W'(MD_CYCLES - 1);
              valid_d    = 1'b0;
              alu_ctrl_d = ALU_NOP;
              illegal_d  = 1'b0;
              md_start_d = 1'b1;
              md_op_d    = dec_md_op;
              busy_d     = 1'b1;
            end else begin
              valid_d    = 1'b1;
              alu_ctrl_d = dec_code;
              illegal_d  = dec_illegal;
            end
          end
        end

        ST_MD_BUSY: begin
          if (cnt_q == '0) begin
            state_d    = ST_MD_DONE;
            valid_d    = 1'b1;
            alu_ctrl_d = ALU_NOP;
            illegal_d  = 1'b0;
            busy_d     = 1'b0;
            hilo_we_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        ST_MD_DONE: begin
          if (ready_i) begin
            state_d   = ST_IDLE;
            valid_d   = 1'b0;
            hilo_we_d = 1'b0;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          hilo_we_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      alu_ctrl_q <= ALU_NOP;
      illegal_q  <= 1'b0;
      md_start_q <= 1'b0;
      md_op_q    <= MD_MULT;
      busy_q     <= 1'b0;
      hilo_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      alu_ctrl_q <= alu_ctrl_d;
      illegal_q  <= illegal_d;
      md_start_q <= md_start_d;
      md_op_q    <= md_op_d;
      busy_q     <= busy_d;
      hilo_we_q  <= hilo_we_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready_o    = ready;
  assign valid_o    = valid_q;
  assign ALUCtrl_o  = CTRL_W'(alu_ctrl_q);  // zero-extended above bit 3
  assign illegal_o  = illegal_q;
  assign md_start_o = md_start_q;
  assign md_op_o    = md_op_q;
  assign busy_o     = busy_q;
  assign hilo_we_o  = hilo_we_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_mc
// Self-checking bench for alu_ctrl_mc (CTRL_W=6, MD_CYCLES=4). Expected
// results are queued when a request is driven and compared when the DUT
// hands a result over (valid_o && ready_i).
// -----------------------------------------------------------------------------
module tb_alu_ctrl_mc;

  localparam int TB_CTRL_W = 6;
  localparam int TB_MD     = 4;

  localparam logic [5:0] C_AND = 6'h00;
  localparam logic [5:0] C_OR  = 6'h01;
  localparam logic [5:0] C_ADD = 6'h02;
  localparam logic [5:0] C_SLT = 6'h07;
  localparam logic [5:0] C_NOR = 6'h0C;
  localparam logic [5:0] C_NOP = 6'h0F;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [5:0]           funct_i;
  logic [3:0]           ALUOp_i;
  logic                 flush_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [TB_CTRL_W-1:0] ALUCtrl_o;
  logic                 illegal_o;
  logic                 md_start_o;
  logic [1:0]           md_op_o;
  logic                 busy_o;
  logic                 hilo_we_o;

  alu_ctrl_mc #(.CTRL_W(TB_CTRL_W), .MD_CYCLES(TB_MD)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .funct_i    (funct_i),
    .ALUOp_i    (ALUOp_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .ALUCtrl_o  (ALUCtrl_o),
    .illegal_o  (illegal_o),
    .md_start_o (md_start_o),
    .md_op_o    (md_op_o),
    .busy_o     (busy_o),
    .hilo_we_o  (hilo_we_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [TB_CTRL_W-1:0] code;
    logic                 ill;
    logic                 hilo;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   excl_viol = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request for one clock edge; valid_i stays high afterwards so
  // back-to-back requests can follow directly.
  task automatic drive_req(input logic [3:0] op, input logic [5:0] fn,
                           input logic [5:0] code, input logic ill,
                           input logic hilo, input bit push);
    exp_t e;
    ALUOp_i = op;
    funct_i = fn;
    valid_i = 1'b1;
    #1;
    check("acc_ready", ready_o, 1'b1);
    if (push) begin
      e.code = code; e.ill = ill; e.hilo = hilo;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"},   valid_o,    1'b0);
    check({tag, "_ctrl"},    ALUCtrl_o,  C_NOP);
    check({tag, "_illegal"}, illegal_o,  1'b0);
    check({tag, "_mdstart"}, md_start_o, 1'b0);
    check({tag, "_mdop"},    md_op_o,    2'b00);
    check({tag, "_busy"},    busy_o,     1'b0);
    check({tag, "_hilo"},    hilo_we_o,  1'b0);
  endtask

  // Scoreboard: compare at each result transfer.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_code", ALUCtrl_o, e.code);
        check("sb_illegal", illegal_o, e.ill);
        check("sb_hilo", hilo_we_o, e.hilo);
      end
    end
    if ((md_start_o && hilo_we_o) || (md_start_o && illegal_o) || (hilo_we_o && illegal_o))
      excl_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; funct_i = '0; ALUOp_i = '0;
    flush_i = 1'b0; ready_i = 1'b1;
    tick(); tick();
    check_reset_vals("rst");
    rst_i = 1'b0;
    #1;
    check("rst_ready", ready_o, 1'b1);

    // SLT through the R-type path, one-cycle latency.
    drive_req(4'b0000, 6'b101010, C_SLT, 1'b0, 1'b0, 1'b1);
    valid_i = 1'b0;
    check("slt_valid", valid_o, 1'b1);
    check("slt_ctrl", ALUCtrl_o, C_SLT);
    check("slt_illegal", illegal_o, 1'b0);
    tick();

    // Back-to-back add / or / nor.
    drive_req(4'b0000, 6'b100000, C_ADD, 1'b0, 1'b0, 1'b1);
    check("b2b0_valid", valid_o, 1'b1);
    drive_req(4'b0000, 6'b100101, C_OR, 1'b0, 1'b0, 1'b1);
    check("b2b1_valid", valid_o, 1'b1);
    drive_req(4'b0000, 6'b100111, C_NOR, 1'b0, 1'b0, 1'b1);
    check("b2b2_valid", valid_o, 1'b1);
    check("b2b2_ready", ready_o, 1'b1);
    valid_i = 1'b0;
    tick();
    check("b2b_drained", valid_o, 1'b0);

    // Direct op classes.
    drive_req(4'b0101, 6'b111111, C_AND, 1'b0, 1'b0, 1'b1);
    drive_req(4'b0001, 6'b000000, C_ADD, 1'b0, 1'b0, 1'b1);
    // Illegal ALUOp, then illegal funct.
    drive_req(4'b0111, 6'b100000, C_NOP, 1'b1, 1'b0, 1'b1);
    check("illop_flag", illegal_o, 1'b1);
    check("illop_ctrl", ALUCtrl_o, C_NOP);
    drive_req(4'b0000, 6'b111111, C_NOP, 1'b1, 1'b0, 1'b1);
    valid_i = 1'b0;
    check("illfn_flag", illegal_o, 1'b1);
    check("illfn_ctrl", ALUCtrl_o, C_NOP);
    tick();

    // Backpressure: result held stable for 3 cycles.
    ready_i = 1'b0;
    drive_req(4'b0001, 6'b000000, C_ADD, 1'b0, 1'b0, 1'b1);
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", valid_o, 1'b1);
      check("hold_ctrl", ALUCtrl_o, C_ADD);
      check("hold_ready", ready_o, 1'b0);
      tick();
    end
    ready_i = 1'b1;
    #1;
    check("hold_release_ready", ready_o, 1'b1);
    tick();
    check("hold_drained", valid_o, 1'b0);

    // div: start pulse, 4 busy cycles, result at accept+5.
    drive_req(4'b0000, 6'b011010, C_NOP, 1'b0, 1'b1, 1'b1);
    valid_i = 1'b0;
    check("div_start", md_start_o, 1'b1);
    check("div_op", md_op_o, 2'b10);
    check("div_busy1", busy_o, 1'b1);
    check("div_ready1", ready_o, 1'b0);
    for (int c = 2; c <= TB_MD; c++) begin
      tick();
      check("div_busy", busy_o, 1'b1);
      check("div_nostart", md_start_o, 1'b0);
      check("div_novalid", valid_o, 1'b0);
      check("div_ready", ready_o, 1'b0);
    end
    tick();
    check("div_done_valid", valid_o, 1'b1);
    check("div_done_hilo", hilo_we_o, 1'b1);
    check("div_done_busy", busy_o, 1'b0);
    check("div_done_ctrl", ALUCtrl_o, C_NOP);
    check("div_done_ready", ready_o, 1'b0);
    tick();
    check("div_idle_valid", valid_o, 1'b0);
    check("div_idle_ready", ready_o, 1'b1);

    // mult with the consumer stalled in MD_DONE.
    ready_i = 1'b0;
    drive_req(4'b0000, 6'b011000, C_NOP, 1'b0, 1'b1, 1'b1);
    valid_i = 1'b0;
    check("mult_op", md_op_o, 2'b00);
    repeat (TB_MD) tick();
    for (int i = 0; i < 2; i++) begin
      check("mdone_hold_valid", valid_o, 1'b1);
      check("mdone_hold_hilo", hilo_we_o, 1'b1);
      tick();
    end
    ready_i = 1'b1;
    #1;
    check("mdone_ready_still0", ready_o, 1'b0);
    tick();
    check("mdone_exit_hilo", hilo_we_o, 1'b0);
    check("mdone_exit_ready", ready_o, 1'b1);

    // Flush drops a request presented in the same cycle.
    flush_i = 1'b1;
    drive_req(4'b0001, 6'b000000, C_ADD, 1'b0, 1'b0, 1'b0);
    valid_i = 1'b0;
    flush_i = 1'b0;
    check("flush_drop_valid", valid_o, 1'b0);

    // Flush in MD_BUSY: no result, no HI/LO write.
    drive_req(4'b0000, 6'b011011, C_NOP, 1'b0, 1'b1, 1'b0);
    valid_i = 1'b0;
    check("divu_op", md_op_o, 2'b11);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_busy", busy_o, 1'b0);
    check("flush_valid", valid_o, 1'b0);
    check("flush_ready", ready_o, 1'b1);
    repeat (TB_MD + 2) tick();
    check("flush_no_hilo", hilo_we_o, 1'b0);
    check("flush_no_valid", valid_o, 1'b0);

    // Reset in MD_DONE abandons the result.
    ready_i = 1'b0;
    drive_req(4'b0000, 6'b011001, C_NOP, 1'b0, 1'b1, 1'b0);
    valid_i = 1'b0;
    repeat (TB_MD) tick();
    check("pre_rst_hilo", hilo_we_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    ready_i = 1'b1;
    check_reset_vals("mdrst");
    #1;
    check("mdrst_ready", ready_o, 1'b1);
    tick();
    check("mdrst_no_valid", valid_o, 1'b0);

    check("sb_drained", sb.size(), 0);
    check("exclusive_flags", excl_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_mc.md
ALU_CTRL_MC -- requirements
Module: alu_ctrl_mc

Interface
REQ-001 SHALL have parameter CTRL_W, default 4, meaning ALUCtrl_o width; legal values >= 4, and codes are zero-extended above bit 3.
REQ-002 SHALL have parameter MD_CYCLES, default 32, meaning busy cycles for mult/div; legal range 2..255.
REQ-003 SHALL have ports: clk_i  in  1  clock, rising edge.
REQ-004 SHALL have ports: rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: valid_i  in  1  request valid; ready_o  out  1  request accepted when valid_i&ready_o.
REQ-006 SHALL have ports: funct_i  in  6  R-type funct; ALUOp_i  in  4  main-decoder ALU op class.
REQ-007 SHALL have ports: flush_i  in  1  abort in-flight operation.
REQ-008 SHALL have ports: valid_o  out  1  result valid; ready_i  in  1  consumer ready.
REQ-009 SHALL have ports: ALUCtrl_o  out  CTRL_W  registered ALU control; illegal_o  out  1  undecodable request, qualified by valid_o.
REQ-010 SHALL have ports: md_start_o  out  1  one-cycle mult/div start; md_op_o  out  2  00 mult, 01 multu, 10 div, 11 divu; busy_o  out  1  mult/div in progress; hilo_we_o  out  1  HI/LO write, qualified by valid_o.

Function
REQ-011 SHALL use ALU codes AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, PASS_HI 1000, PASS_LO 1001, NOR 1100, NOP 1111.
REQ-012 SHALL decode ALUOp_i: 0000 R-type (funct), 0001 ADD, 0010 SUB, 0011 SLT, 0100 OR, 0101 AND; any other value is illegal.
REQ-013 SHALL decode funct_i under R-type: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000000 SLL, 000010 SRL, 010000 PASS_HI, 010010 PASS_LO, 011000..011011 mult/multu/div/divu (md_op_o = funct_i[1:0]); any other value is illegal.
REQ-014 SHALL implement states IDLE, MD_BUSY, MD_DONE.
REQ-015 SHALL drive ready_o = (state==IDLE) && (!valid_o || ready_i).
REQ-016 IDLE, accepted single-cycle or illegal op: valid_o=1 on the next cycle, carrying the code, or NOP with illegal_o=1 for an illegal op; latency is 1 cycle; back-to-back accepts SHALL be possible every cycle while ready_i=1.
REQ-017 IDLE, accepted mult/div: md_start_o=1 and md_op_o valid for exactly the next cycle; state goes to MD_BUSY; the counter loads MD_CYCLES-1; busy_o=1.
REQ-018 MD_BUSY: the counter decrements each cycle; at 0 the state goes to MD_DONE; total cycles from accept to valid_o = MD_CYCLES+1.
REQ-019 MD_DONE: valid_o=1, hilo_we_o=1, ALUCtrl_o=NOP, busy_o=0; both held until ready_i=1, then the state goes to IDLE.
REQ-020 Any state with valid_o=1 and ready_i=0: all outputs SHALL hold stable.
REQ-021 flush_i=1: the state goes to IDLE next cycle, valid_o, md_start_o, busy_o and hilo_we_o clear, and the counter clears; a request presented in the same cycle is dropped; rst_i SHALL take priority over flush_i.
REQ-022 md_start_o, hilo_we_o and illegal_o SHALL never be 1 in the same cycle as each other.

Reset
REQ-023 rst_i=1 at a clock edge: state IDLE, counter 0, valid_o=0, ALUCtrl_o=NOP, illegal_o=0, md_start_o=0, md_op_o=00, busy_o=0, hilo_we_o=0.
REQ-024 Reset during MD_BUSY or MD_DONE SHALL abandon the operation with no hilo_we_o pulse; ready_o SHALL be 1 on the first cycle after reset is released.

Structure
REQ-025 ALU codes, ALUOp classes, funct constants, md_op encodings and the state enum SHALL live in shared package alu_ctrl_pkg.
REQ-026 Combinational decode SHALL be sub-module alu_dec (ALUOp_i, funct_i -> code, is_md, md_op, illegal); alu_ctrl_mc registers its outputs and holds the FSM and counter.

Verification
REQ-027 Reset, then ALUOp=0000 funct=101010 valid_i=1 ready_i=1 -> next cycle valid_o=1, ALUCtrl_o=0111, illegal_o=0.
REQ-028 Three back-to-back requests add/or/nor with ready_i=1 -> valid_o on three consecutive cycles, codes 0010/0001/1100, ready_o stays 1.
REQ-029 MD_CYCLES=4, funct=011010 -> md_start_o=1 with md_op_o=10 the next cycle, busy_o=1 for 4 cycles, valid_o and hilo_we_o=1 at accept+5, ready_o=0 throughout.
REQ-030 ALUOp=0111 -> valid_o=1, ALUCtrl_o=1111, illegal_o=1; separately ALUOp=0000 funct=111111 -> the same response.
REQ-031 Result pending with ready_i=0 for 3 cycles -> outputs stable and ready_o=0; ready_i=1 -> ready_o=1 the same cycle.
REQ-032 flush_i during MD_BUSY -> IDLE next cycle with no hilo_we_o; rst_i during MD_DONE -> all outputs at reset values.
